mdu_iter: RTL and testbench

- Parametrised, multi-cycle multiply/divide unit. It is the iterative companion to the core's single-cycle ALU and implements the full RV32M op set (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) at width XLEN.
- Sits in the EX stage beside the ALU. The pipeline stalls while the unit is busy.
- Uses one shared shift/add-subtract datapath, valid/ready handshakes on both sides, and a flush input for branch/exception squash.

---
 rtl/mdu_pkg.sv | 33 +++
 rtl/mdu_step.sv | 42 ++++
 rtl/mdu_iter.sv | 181 ++++++++++++++++++
 tb/tb_mdu_iter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: RV32M funct3
// op codes, FSM state encoding and operand-signedness helpers.
package mdu_pkg;

  localparam logic [2:0] MUL    = 3'd0;
  localparam logic [2:0] MULH   = 3'd1;
  localparam logic [2:0] MULHSU = 3'd2;
  localparam logic [2:0] MULHU  = 3'd3;
  localparam logic [2:0] DIV    = 3'd4;
  localparam logic [2:0] DIVU   = 3'd5;
  localparam logic [2:0] REM    = 3'd6;
  localparam logic [2:0] REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic is_div(input logic [2:0] f);
    return f[2];
  endfunction

  function automatic logic is_signed_a(input logic [2:0] f);
    return (f == MULH) || (f == MULHSU) || (f == DIV) || (f == REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] f);
    return (f == MULH) || (f == DIV) || (f == REM);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One combinational iteration of the shared datapath: radix-2 shift-add
// multiply step, or restoring-divide trial subtract producing one quotient bit.
module mdu_step #(
  parameter int XLEN = 32
) (
  input  logic              i_div,
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_opd,
  output logic [2*XLEN-1:0] o_acc
);

  logic [XLEN:0]   w_mul_sum;
  logic [XLEN:0]   w_rem_sh;
  logic [XLEN:0]   w_rem_sub;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_new;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  always_comb begin
    w_mul_sum = {1'b0, i_acc[2*XLEN-1:XLEN]};
    if (i_acc[0]) begin
      w_mul_sum = {1'b0, i_acc[2*XLEN-1:XLEN]} + {1'b0, i_opd};
    end
  end

  // Divide: acc = {partial remainder, remaining dividend bits / quotient bits}.
  always_comb begin
    w_rem_sh  = {i_acc[2*XLEN-1:XLEN], i_acc[XLEN-1]};
    w_rem_sub = w_rem_sh - {1'b0, i_opd};
    w_ge      = (w_rem_sh >= {1'b0, i_opd});
    w_rem_new = w_ge ? w_rem_sub[XLEN-1:0] : w_rem_sh[XLEN-1:0];
  end

  always_comb begin
    if (i_div) begin
      o_acc = {w_rem_new, i_acc[XLEN-2:0], w_ge};
    end else begin
      o_acc = {w_mul_sum, i_acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: one shared shift/add-subtract step
// per cycle, sign fix-up in a dedicated cycle, valid/ready on both sides.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opd;
  logic [2:0]        r_op;
  logic              r_neg_main;
  logic              r_neg_rem;
  logic [XLEN-1:0]   r_result;
  logic              r_out_valid;

  logic              w_in_ready;
  logic              w_out_valid_next;
  logic              w_accept;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_div_zero;
  logic              w_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_special_res;
  logic [2*XLEN-1:0] w_acc_next;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_fix_res;
  logic              w_is_div;

  assign w_accept = in_valid && w_in_ready && !flush;
  assign w_is_div = is_div(r_op);

  // Magnitudes of the incoming operands; the most-negative value maps to 2^(XLEN-1).
  always_comb begin
    w_a_neg = is_signed_a(op) && op1[XLEN-1];
    w_b_neg = is_signed_b(op) && op2[XLEN-1];
    w_a_mag = w_a_neg ? -op1 : op1;
    w_b_mag = w_b_neg ? -op2 : op2;
  end

  always_comb begin
    w_div_zero    = is_div(op) && (op2 == '0);
    w_ovf         = ((op == DIV) || (op == REM)) && (op1 == MOST_NEG) && (op2 == '1);
    w_special     = w_div_zero || w_ovf;
    w_special_res = '0;
    if (w_div_zero) begin
      w_special_res = ((op == DIV) || (op == DIVU)) ? '1 : op1;
    end else if (w_ovf) begin
      w_special_res = (op == DIV) ? op1 : '0;
    end
  end

  mdu_step #(
    .XLEN (XLEN)
  ) u_step (
    .i_div (w_is_div),
    .i_acc (r_acc),
    .i_opd (r_opd),
    .o_acc (w_acc_next)
  );

  // Sign correction applied in FIX on the magnitude result.
  always_comb begin
    w_prod_fix = r_neg_main ? -r_acc : r_acc;
    w_fix_res  = '0;
    case (r_op)
      MUL:           w_fix_res = r_acc[XLEN-1:0];
      MULH, MULHSU:  w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
      MULHU:         w_fix_res = r_acc[2*XLEN-1:XLEN];
      DIV:           w_fix_res = r_neg_main ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
      DIVU:          w_fix_res = r_acc[XLEN-1:0];
      REM:           w_fix_res = r_neg_rem ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
      REMU:          w_fix_res = r_acc[2*XLEN-1:XLEN];
      default:       w_fix_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (in_valid) w_state_next = w_special ? DONE : CALC;
        CALC:    if (r_cnt == '0) w_state_next = FIX;
        FIX:     w_state_next = DONE;
        DONE:    if (r_out_valid && out_ready) w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // out_valid lags entry into DONE by one edge so the result register is settled first.
  always_comb begin
    w_in_ready       = (r_state == IDLE);
    w_out_valid_next = !flush && (r_state == DONE) && !(r_out_valid && out_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_acc       <= '0;
      r_opd       <= '0;
      r_op        <= '0;
      r_neg_main  <= 1'b0;
      r_neg_rem   <= 1'b0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_out_valid_next;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op       <= op;
            r_cnt      <= CNT_W'(XLEN - 1);
            r_neg_main <= w_a_neg ^ w_b_neg;
            r_neg_rem  <= w_a_neg;
            if (is_div(op)) begin
              r_acc <= {{XLEN{1'b0}}, w_a_mag};
              r_opd <= w_b_mag;
            end else begin
              r_acc <= {{XLEN{1'b0}}, w_b_mag};
              r_opd <= w_a_mag;
            end
            if (w_special) begin
              r_result <= w_special_res;
            end
          end
        end
        CALC: begin
          if (!flush) begin
            r_acc <= w_acc_next;
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
        end
        FIX: begin
          if (!flush) begin
            r_result <= w_fix_res;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed + randomized bench for mdu_iter; results checked against a
// 64-bit arithmetic reference model of the RV32M rules.
module tb_mdu_iter;
  import mdu_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            flush = 1'b0;
  logic            out_ready = 1'b0;
  logic [2:0]      op = '0;
  logic [XLEN-1:0] op1 = '0;
  logic [XLEN-1:0] op2 = '0;
  logic            in_ready;
  logic            out_valid;
  logic [XLEN-1:0] result;

  int n_checks = 0;
  int n_pass   = 0;

  mdu_iter #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .op1       (op1),
    .op2       (op2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint     sa, sb, ua, ub;
    logic [63:0] p;
    bit          ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      MUL:    begin p = 64'(ua * ub); return p[31:0];  end
      MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
      MULHU:  begin p = 64'(ua * ub); return p[63:32]; end
      DIV:    begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = 64'(sa / sb); return p[31:0];
      end
      DIVU:   begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = 64'(ua / ub); return p[31:0];
      end
      REM:    begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = 64'(sa % sb); return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = 64'(ua % ub); return p[31:0];
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0)) return 1;
    if (((f == DIV) || (f == REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
    return XLEN + 2;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  // Issue one request, wait (bounded) for the result, check latency/value/busy handshake.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit release_out);
    int guard = 0;
    int lat = 0;
    int busy_ready = 0;
    while (!in_ready && guard < 100) begin
      tick();
      guard++;
    end
    op = f; op1 = a; op2 = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    op = 3'($urandom_range(0, 7)); op1 = $urandom; op2 = $urandom;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_ready++;
      tick();
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat(f, a, b)));
    chk({tag, " result"}, result, exp);
    chk({tag, " in_ready_busy"}, 64'(busy_ready), 64'd0);
    $display("txn %s op=%0d a=%h b=%h result=%h lat=%0d", tag, f, a, b, result, lat);
    if (release_out) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] saved;
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    int          seen;

    #2;
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset result", result, 32'h0);
    #10 rst_n = 1'b1;
    tick();
    chk("reset in_ready", in_ready, 1'b1);

    run_op("mul", MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
    run_op("mulh", MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1);
    run_op("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
    run_op("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_op("div", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1);
    run_op("rem", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1);
    run_op("divu", DIVU, 32'd100, 32'd7, 32'd14, 1'b1);
    run_op("remu", REMU, 32'd100, 32'd7, 32'd2, 1'b1);
    run_op("div0", DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
    run_op("remu0", REMU, 32'd5, 32'd0, 32'd5, 1'b1);
    run_op("divovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    run_op("removf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1);

    // Backpressure: result must hold for 10 cycles.
    run_op("bp", MULHU, 32'h1234_5678, 32'h9ABC_DEF0,
           ref_mdu(MULHU, 32'h1234_5678, 32'h9ABC_DEF0), 1'b0);
    saved = result;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp hold", {out_valid, in_ready, result}, {1'b1, 1'b0, saved});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp release out_valid", out_valid, 1'b0);
    chk("bp release in_ready", in_ready, 1'b1);
    run_op("bp next", REMU, 32'd1000, 32'd33, 32'd10, 1'b1);

    // Flush during CALC.
    op = DIVU; op1 = 32'd1000; op2 = 32'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush calc in_ready", in_ready, 1'b1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      tick();
    end
    chk("flush calc no valid", 64'(seen), 64'd0);
    run_op("after flush", DIVU, 32'd9, 32'd3, 32'd3, 1'b1);

    // Flush on the same edge as an accept.
    op = MUL; op1 = 32'd3; op2 = 32'd4; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush accept in_ready", in_ready, 1'b1);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) seen++;
      tick();
    end
    chk("flush accept no valid", 64'(seen), 64'd0);

    // Flush while the result waits in DONE.
    run_op("flush done", DIV, 32'd77, 32'hFFFF_FFF5, 32'hFFFF_FFF9, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush done out_valid", out_valid, 1'b0);
    chk("flush done in_ready", in_ready, 1'b1);

    // Asynchronous reset mid-CALC.
    op = MUL; op1 = 32'd123; op2 = 32'd456; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst mid out_valid", out_valid, 1'b0);
    chk("rst mid result", result, 32'h0);
    chk("rst mid in_ready", in_ready, 1'b1);
    #2 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      run_op("rnd", rf, ra, rb, ref_mdu(rf, ra, rb), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
